// File: rtl/sign_mag_table_writer.sv
// rtl/sign_mag_table_writer.sv - sweeps every {a,b} pair and writes the sign-magnitude sum a+b to a table
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   start      request a full table sweep (honoured only while idle)
//   busy       high while the sweep is writing
//   done       one-cycle pulse after the final entry is accepted
//   wr_en      write request to the table memory
//   wr_ready   memory accepts the presented write this cycle
//   wr_addr    table address {a,b}; a in the upper N bits, b in the lower N bits
//   wr_data    sign-magnitude a+b for the presented address
//   ovf_count  overflowing entries written in the current or last sweep
module sign_mag_table_writer #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    input  logic             wr_ready,
    output logic [2*N-1:0]   wr_addr,
    output logic [N-1:0]     wr_data,
    output logic [2*N:0]     ovf_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2*N-1:0] LAST_ADDR = '1;

    state_t         state;
    state_t         state_nxt;
    logic [2*N-1:0] addr;
    logic           accept;
    logic           last;
    logic           entry_ovf;

    logic           sa;
    logic           sb;
    logic [N-2:0]   ma;
    logic [N-2:0]   mb;
    logic [N-2:0]   mag;
    logic [N-1:0]   msum;
    logic           sgn;

    assign accept  = (state == WRITE) && wr_ready;
    assign last    = (addr == LAST_ADDR);
    assign wr_addr = addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            ovf_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                addr      <= '0;
                ovf_count <= '0;
            end else if (accept) begin
                // The final address stays put so the table is never rewritten from 0.
                if (!last) begin
                    addr <= addr + 1'b1;
                end
                if (entry_ovf) begin
                    ovf_count <= ovf_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Entry arithmetic is purely combinational on the presented address, so data
    // can never lag the address during a stall.
    always_comb begin
        sa        = addr[2*N-1];
        ma        = addr[2*N-2:N];
        sb        = addr[N-1];
        mb        = addr[N-2:0];
        msum      = {1'b0, ma} + {1'b0, mb};
        mag       = '0;
        sgn       = 1'b0;
        entry_ovf = 1'b0;
        if (sa == sb) begin
            mag       = msum[N-2:0];
            sgn       = sa;
            entry_ovf = msum[N-1];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = sa;
        end else begin
            mag = mb - ma;
            sgn = sb;
        end
        // A zero magnitude is always written as +0.
        if (mag == '0) begin
            sgn = 1'b0;
        end
        wr_data = {sgn, mag};
    end

endmodule

// File: tb/tb_sign_mag_table_writer.sv
// tb/tb_sign_mag_table_writer.sv - directed self-checking bench for sign_mag_table_writer
module tb_sign_mag_table_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [3:0] wr_data;
    logic [8:0] ovf_count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cap [256];

    sign_mag_table_writer #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: add the operands as signed integers, then fold back to sign-magnitude.
    function automatic int ref_sum(input logic [7:0] ad);
        int va;
        int vb;
        va = ad[7] ? -int'(ad[6:4]) : int'(ad[6:4]);
        vb = ad[3] ? -int'(ad[2:0]) : int'(ad[2:0]);
        return va + vb;
    endfunction

    function automatic logic [3:0] ref_entry(input logic [7:0] ad);
        int s;
        int m;
        int mg;
        s  = ref_sum(ad);
        m  = (s < 0) ? -s : s;
        mg = m % 8;
        return {((s < 0) && (mg != 0)), mg[2:0]};
    endfunction

    function automatic bit ref_ovf(input logic [7:0] ad);
        int s;
        s = ref_sum(ad);
        return (s >= 8) || (s <= -8);
    endfunction

    // Watches one sweep that has just been started. stall_pct sets the chance of
    // wr_ready=0; poke_start pulses start once mid-WRITE and again during DONE.
    task automatic sweep(input int stall_pct, input bit poke_start);
        int         exp_addr = 0;
        int         cyc      = 0;
        int         n_wr     = 0;
        int         ovf_m    = 0;
        bit         stalled  = 0;
        bit         seen_done = 0;
        bit         rdy;
        logic [7:0] pa = '0;
        logic [3:0] pd = '0;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (stalled) begin
                check("stall_addr", 32'(wr_addr), 32'(pa));
                check("stall_data", 32'(wr_data), 32'(pd));
            end
            stalled = 0;
            if (done) begin
                seen_done = 1;
                check("done_after_ff", exp_addr, 256);
                check("done_wr_en", 32'(wr_en), 0);
                check("done_busy", 32'(busy), 0);
                check("ovf_count", 32'(ovf_count), ovf_m);
                check("wr_cycles", n_wr, (stall_pct == 0) ? 256 : n_wr);
                if (stall_pct == 0) begin
                    check("done_latency", cyc, 256);
                end
                if (poke_start) begin
                    start = 1'b1;
                end
            end else if (wr_en) begin
                n_wr++;
                rdy      = ($urandom_range(0, 99) >= stall_pct);
                wr_ready = rdy;
                if (rdy) begin
                    check("addr_seq", 32'(wr_addr), exp_addr);
                    check("entry", 32'(wr_data), 32'(ref_entry(wr_addr)));
                    cap[wr_addr] = wr_data;
                    if (ref_ovf(wr_addr)) begin
                        ovf_m++;
                    end
                    exp_addr++;
                end else begin
                    stalled = 1;
                    pa      = wr_addr;
                    pd      = wr_data;
                end
                if (poke_start && cyc == 100) begin
                    start = 1'b1;
                end
            end else begin
                check("wr_en_gap", 32'(wr_en), 1);
            end
            cyc++;
        end
        if (!seen_done) begin
            check("sweep_timeout", 0, 1);
        end
        wr_ready = 1'b1;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_wr_en"}, 32'(wr_en), 0);
            check({tag, "_busy"}, 32'(busy), 0);
            check({tag, "_done"}, 32'(done), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] tv_addr [9];
        logic [3:0] tv_data [9];
        int         guard;
        tv_addr = '{8'h30, 8'h4C, 8'h6B, 8'h2D, 8'h23, 8'h66, 8'hAB, 8'hEE, 8'h88};
        tv_data = '{4'b0011, 4'b0000, 4'b0011, 4'b1011, 4'b0101, 4'b0100, 4'b1101, 4'b1100, 4'b0000};

        reset    = 1'b1;
        start    = 1'b1;
        wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_ovf", 32'(ovf_count), 0);
        check("rst_addr", 32'(wr_addr), 0);
        reset = 1'b0;
        start = 1'b0;
        check_idle("idle", 2);

        // Full sweep with wr_ready tied high.
        start = 1'b1;
        sweep(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("tv_%02h", tv_addr[i]), 32'(cap[tv_addr[i]]), 32'(tv_data[i]));
        end
        check_idle("post_done", 3);
        check("idle_addr_hold", 32'(wr_addr), 32'hFF);
        check("idle_ovf_hold", 32'(ovf_count), 56);

        // Random back-pressure.
        start = 1'b1;
        sweep(40, 1'b0);
        check_idle("post_stall", 2);
        check("stall_ovf", 32'(ovf_count), 56);

        // Reset in the middle of a sweep, at address 0x40.
        start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            guard++;
        end while (!(wr_en && wr_addr == 8'h40) && guard < 1000);
        check("reach_0x40", 32'(wr_addr), 32'h40);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovf", 32'(ovf_count), 0);
        check("mid_rst_done", 32'(done), 0);
        check_idle("after_rst", 3);
        start = 1'b1;
        sweep(0, 1'b0);

        // start pulses during WRITE and during DONE must be ignored.
        check_idle("pre_poke", 1);
        start = 1'b1;
        sweep(0, 1'b1);
        check_idle("post_poke", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
